// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the in-order
// writeback stage and a long-latency unit. It tracks pending long destinations
// to stall decode on RAW/WAW hazards, and buffers long results in a small FIFO.
// Optional build macro ARB_TRACE_EN adds $display tracing of rf writes and stalls.
module regfile_wb_arbiter #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_long,
  input  logic [AW-1:0]   issue_dest,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_reg,
  input  logic [DW-1:0]   wb_data,
  output logic            wb_ready,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_reg,
  input  logic [DW-1:0]   lu_data,
  output logic            lu_ready,
  output logic            rf_reg_write,
  output logic [AW-1:0]   rf_write_reg,
  output logic [DW-1:0]   rf_write_data,
  output logic [NREG-1:0] pending
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LU} gnt_e;

  logic [AW-1:0]   fifo_reg_q  [FIFO_DEPTH];
  logic [DW-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_reg_q, rf_reg_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;
  logic            fifo_empty, fifo_full, starved, push, pop, issue_set;
  gnt_e            gnt;

  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign lu_ready      = !fifo_full;
  assign pending       = pending_q;
  assign rf_reg_write  = rf_we_q;
  assign rf_write_reg  = rf_reg_q;
  assign rf_write_data = rf_data_q;

  // Decode hazard detection against outstanding long-latency destinations.
  always_comb begin
    stall = 1'b0;
    if (id_rs != '0 && pending_q[id_rs]) stall = 1'b1;
    if (id_rt != '0 && pending_q[id_rt]) stall = 1'b1;
    if (issue_valid && issue_long && issue_dest != '0 && pending_q[issue_dest])
      stall = 1'b1;
    issue_set = issue_valid && issue_long && !stall && issue_dest != '0;
  end

  // Write-port arbitration, FIFO pointer, starvation and scoreboard next state.
  always_comb begin
    starved  = !fifo_empty && (starve_q == STARVE_LIM);
    gnt      = GNT_NONE;
    if (starved)          gnt = GNT_LU;
    else if (wb_valid)    gnt = GNT_WB;
    else if (!fifo_empty) gnt = GNT_LU;
    wb_ready = !starved;
    pop      = (gnt == GNT_LU);
    // Register-0 results complete the handshake but are dropped here.
    push     = lu_valid && lu_ready && lu_reg != '0;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    starve_d = starve_q;
    if (fifo_empty || pop)                          starve_d = '0;
    else if (gnt == GNT_WB && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;

    // Clear is applied before set so a same-edge issue to the register wins.
    pending_d = pending_q;
    if (pop)       pending_d[fifo_reg_q[rd_ptr_q[PW-1:0]]] = 1'b0;
    if (issue_set) pending_d[issue_dest] = 1'b1;
    pending_d[0] = 1'b0;

    rf_we_d   = 1'b0;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    case (gnt)
      GNT_WB: begin
        rf_we_d   = (wb_reg != '0);
        rf_reg_d  = wb_reg;
        rf_data_d = wb_data;
      end
      GNT_LU: begin
        rf_we_d   = 1'b1;
        rf_reg_d  = fifo_reg_q[rd_ptr_q[PW-1:0]];
        rf_data_d = fifo_data_q[rd_ptr_q[PW-1:0]];
      end
      default: ;
    endcase
  end

  // Control state and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q[PW-1:0]]  <= lu_reg;
      fifo_data_q[wr_ptr_q[PW-1:0]] <= lu_data;
    end
  end

`ifdef ARB_TRACE_EN
  logic trace_src_lu_q;

  // Remember which source produced the write currently on the rf port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trace_src_lu_q <= 1'b0;
    else     trace_src_lu_q <= (gnt == GNT_LU);
  end

  // Trace rf writes and decode stalls.
  always @(posedge clk) begin
    if (!rst && rf_we_q)
      $display("arb: rf write src=%s reg=%0d data=%h",
               trace_src_lu_q ? "LU" : "WB", rf_reg_q, rf_data_q);
    if (!rst && stall)
      $display("arb: stall rs=%0d rt=%0d pending=%h", id_rs, id_rt, pending_q);
  end
`endif

endmodule
